// File: rtl/tt_io_pattern_test_pkg.sv
// rtl/tt_io_pattern_test_pkg.sv - shared mode encodings, defaults and pattern step function
//
// Purpose: constants and the per-mode next-pattern function shared by the
// pattern generator and the top-level decode.
// Ports: none (package).

package tt_io_pattern_test_pkg;

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_WALK = 2'd1;
  localparam logic [1:0] MODE_LFSR = 2'd2;
  localparam logic [1:0] MODE_LOOP = 2'd3;

  localparam logic [7:0] SEED_DEFAULT = 8'h01;
  localparam logic [7:0] TAPS_DEFAULT = 8'hB8;
  localparam logic [7:0] LOOP_OE_MASK = 8'h0F;

  // Next pattern for one step in the given mode; IDLE holds.
  function automatic logic [7:0] pattern_next(input logic [1:0] mode,
                                              input logic [7:0] pat,
                                              input logic [7:0] taps);
    logic [7:0] nxt;
    nxt = pat;
    case (mode)
      MODE_WALK: nxt = {pat[6:0], pat[7]};
      // An all-zero LFSR state would lock up, so it is kicked back to 8'h01.
      MODE_LFSR: nxt = (pat == 8'h00) ? 8'h01 : {pat[6:0], ^(pat & taps)};
      MODE_LOOP: nxt = pat + 8'd1;
      default:   nxt = pat;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/tt_io_pattern_test_if.sv
// rtl/tt_io_pattern_test_if.sv - user I/O bundle of the pattern tester
//
// Purpose: groups the 8-bit user input, status output and bidirectional
// pattern pins.
// Signals: ui_in (mode/clear/hold/rate), uo_out (status), uio_in (loopback
// sense), uio_out (pattern drive), uio_oe (per-bit output enable).
// Modports: master drives ui_in/uio_in, slave (the design) drives the outputs.

interface tt_io_pattern_test_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ui_in, output uio_in,
                  input uo_out, input uio_out, input uio_oe);
  modport slave  (input ui_in, input uio_in,
                  output uo_out, output uio_out, output uio_oe);
endinterface

// File: rtl/tt_io_pattern_gen.sv
// rtl/tt_io_pattern_gen.sv - prescaler, step strobe and pattern register
//
// Purpose: produces one step every rate+1 cycles and advances the pattern
// according to the registered mode.
// Ports: clk, rst_n (sync, active-low), mode (registered mode), reload (mode
// about to change), hold (freeze), rate (prescale R), pattern (current
// pattern), step (pattern advances on this edge).

module tt_io_pattern_gen
  import tt_io_pattern_test_pkg::*;
#(
  parameter logic [7:0] SEED = SEED_DEFAULT,
  parameter logic [7:0] TAPS = TAPS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       reload,
  input  logic       hold,
  input  logic [3:0] rate,
  output logic [7:0] pattern,
  output logic       step
);

  logic [3:0] presc;

  // A reload edge never steps, so the first step after a mode change is a
  // full rate+1 cycles later.
  assign step = !reload && !hold && (presc >= rate);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc   <= 4'd0;
      pattern <= SEED;
    end else if (reload) begin
      presc   <= 4'd0;
      pattern <= SEED;
    end else if (step) begin
      presc   <= 4'd0;
      pattern <= pattern_next(mode, pattern, TAPS);
    end else if (!hold) begin
      presc   <= presc + 4'd1;
    end
  end

endmodule

// File: rtl/tt_io_pattern_test.sv
// rtl/tt_io_pattern_test.sv - I/O pattern generator and loopback checker top
//
// Purpose: drives walking-one, LFSR or counting patterns on the uio pins and,
// in LOOP mode, counts mismatches between the driven nibble and uio_in[7:4].
// Ports: clk, rst_n (sync, active-low), VGND/VDPWR (power, unused), ena
// (unused), ua (analog, unconnected), io (ui_in mode/clear/hold/rate,
// uo_out status, uio_in sense, uio_out drive, uio_oe enables).

module tt_io_pattern_test
  import tt_io_pattern_test_pkg::*;
#(
  parameter logic [7:0] SEED  = SEED_DEFAULT,
  parameter logic [7:0] TAPS  = TAPS_DEFAULT,
  parameter int         ERR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 VGND,
  input  logic                 VDPWR,
  input  logic                 ena,
  inout  wire  [7:0]           ua,
  tt_io_pattern_test_if.slave  io
);

  logic [1:0]       mode_q;
  logic [ERR_W-1:0] err_cnt;
  logic [7:0]       err_ext;
  logic [7:0]       pattern;
  logic             step;
  logic             reload;
  logic             err_clr;
  logic             mismatch;

  wire unused_pins = &{1'b0, VGND, VDPWR, ena, ua, io.uio_in[3:0]};

  assign reload   = (io.ui_in[1:0] != mode_q);
  assign err_clr  = io.ui_in[2];
  // The sense nibble is compared against the pattern still on the pins,
  // i.e. before this step's update.
  assign mismatch = step && (mode_q == MODE_LOOP) &&
                    (io.uio_in[7:4] != pattern[3:0]);

  tt_io_pattern_gen #(
    .SEED (SEED),
    .TAPS (TAPS)
  ) u_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode_q),
    .reload  (reload),
    .hold    (io.ui_in[3]),
    .rate    (io.ui_in[7:4]),
    .pattern (pattern),
    .step    (step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q  <= MODE_IDLE;
      err_cnt <= '0;
    end else begin
      mode_q <= io.ui_in[1:0];
      if (err_clr) begin
        err_cnt <= '0;
      end else if (mismatch && !(&err_cnt)) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

  always_comb begin
    err_ext = '0;
    err_ext[ERR_W-1:0] = err_cnt;
  end

  // Outputs depend on registered state only.
  always_comb begin
    io.uo_out  = 8'h00;
    io.uio_out = 8'h00;
    io.uio_oe  = 8'h00;
    case (mode_q)
      MODE_WALK, MODE_LFSR: begin
        io.uo_out  = pattern;
        io.uio_out = pattern;
        io.uio_oe  = 8'hFF;
      end
      MODE_LOOP: begin
        io.uo_out  = err_ext;
        io.uio_out = {4'b0000, pattern[3:0]};
        io.uio_oe  = LOOP_OE_MASK;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tt_io_pattern_test.sv
// tb/tb_tt_io_pattern_test.sv - self-checking bench for tt_io_pattern_test

module tb_tt_io_pattern_test;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic vgnd  = 1'b0;
  logic vdpwr = 1'b1;
  logic ena   = 1'b1;
  wire [7:0] ua1 = 8'h00;
  wire [7:0] ua2 = 8'h00;

  tt_io_pattern_test_if io1 ();
  tt_io_pattern_test_if io2 ();

  logic       tie1;
  logic [7:0] uio_drv1;
  logic [7:0] uio_drv2;

  assign io1.uio_in = tie1 ? {io1.uio_out[3:0], 4'h0} : uio_drv1;
  assign io2.uio_in = uio_drv2;

  tt_io_pattern_test dut (
    .clk   (clk),
    .rst_n (rst_n),
    .VGND  (vgnd),
    .VDPWR (vdpwr),
    .ena   (ena),
    .ua    (ua1),
    .io    (io1)
  );

  // Zero taps drive the LFSR to 0 after 8 steps; 2-bit error counter.
  tt_io_pattern_test #(
    .SEED  (8'h01),
    .TAPS  (8'h00),
    .ERR_W (2)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .VGND  (vgnd),
    .VDPWR (vdpwr),
    .ena   (ena),
    .ua    (ua2),
    .io    (io2)
  );

  typedef struct {
    logic       rst_n;
    logic [7:0] ui;
    logic [7:0] uio;
    logic [7:0] uo;
    logic [7:0] uio_o;
    logic [7:0] oe;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic add(input logic r, input logic [7:0] ui, input logic [7:0] uio,
                     input logic [7:0] uo, input logic [7:0] uio_o, input logic [7:0] oe);
    vec_t v;
    v.rst_n = r; v.ui = ui; v.uio = uio; v.uo = uo; v.uio_o = uio_o; v.oe = oe;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lfsr_ref(input logic [7:0] p);
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
  endfunction

  initial begin
    logic [7:0] p;
    logic [7:0] e;
    logic [7:0] walk;
    logic       seen_zero;
    int         period;
    logic [7:0] exp2 [10];

    rst_n = 1'b0;
    tie1 = 1'b0;
    uio_drv1 = 8'h00;
    uio_drv2 = 8'h00;
    io1.ui_in = 8'h00;
    io2.ui_in = 8'h00;

    // Reset then WALK at R=0.
    add(0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    add(0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 8'h01, 8'h00, 8'h01, 8'h01, 8'hFF);
    walk = 8'h01;
    for (int i = 0; i < 8; i++) begin
      walk = {walk[6:0], walk[7]};
      add(1, 8'h01, 8'h00, walk, walk, 8'hFF);
    end
    // WALK at R=3, then hold for 10 cycles, then resume.
    add(1, 8'h31, 8'h00, 8'h01, 8'h01, 8'hFF);
    add(1, 8'h31, 8'h00, 8'h01, 8'h01, 8'hFF);
    add(1, 8'h31, 8'h00, 8'h01, 8'h01, 8'hFF);
    add(1, 8'h31, 8'h00, 8'h02, 8'h02, 8'hFF);
    add(1, 8'h31, 8'h00, 8'h02, 8'h02, 8'hFF);
    add(1, 8'h31, 8'h00, 8'h02, 8'h02, 8'hFF);
    add(1, 8'h31, 8'h00, 8'h02, 8'h02, 8'hFF);
    add(1, 8'h31, 8'h00, 8'h04, 8'h04, 8'hFF);
    for (int i = 0; i < 10; i++) add(1, 8'h39, 8'h00, 8'h04, 8'h04, 8'hFF);
    add(1, 8'h31, 8'h00, 8'h04, 8'h04, 8'hFF);
    add(1, 8'h31, 8'h00, 8'h04, 8'h04, 8'hFF);
    add(1, 8'h31, 8'h00, 8'h04, 8'h04, 8'hFF);
    add(1, 8'h31, 8'h00, 8'h08, 8'h08, 8'hFF);
    // LOOP: mismatches, a match, clear-with-mismatch, then reset mid-LOOP.
    add(1, 8'h03, 8'h00, 8'h00, 8'h01, 8'h0F);
    add(1, 8'h03, 8'h00, 8'h01, 8'h02, 8'h0F);
    add(1, 8'h03, 8'h00, 8'h02, 8'h03, 8'h0F);
    add(1, 8'h03, 8'h30, 8'h02, 8'h04, 8'h0F);
    add(1, 8'h07, 8'h00, 8'h00, 8'h05, 8'h0F);
    add(1, 8'h03, 8'h00, 8'h01, 8'h06, 8'h0F);
    add(0, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 8'h03, 8'h00, 8'h00, 8'h01, 8'h0F);
    // Error count persists across a WALK excursion.
    add(1, 8'h03, 8'h00, 8'h01, 8'h02, 8'h0F);
    add(1, 8'h01, 8'h00, 8'h01, 8'h01, 8'hFF);
    add(1, 8'h03, 8'h00, 8'h01, 8'h01, 8'h0F);
    // WALK (R=3) -> LFSR switch mid-prescale reloads SEED and clears prescaler.
    add(1, 8'h31, 8'h00, 8'h01, 8'h01, 8'hFF);
    add(1, 8'h31, 8'h00, 8'h01, 8'h01, 8'hFF);
    add(1, 8'h31, 8'h00, 8'h01, 8'h01, 8'hFF);
    add(1, 8'h31, 8'h00, 8'h01, 8'h01, 8'hFF);
    add(1, 8'h31, 8'h00, 8'h02, 8'h02, 8'hFF);
    add(1, 8'h31, 8'h00, 8'h02, 8'h02, 8'hFF);
    add(1, 8'h31, 8'h00, 8'h02, 8'h02, 8'hFF);
    add(1, 8'h32, 8'h00, 8'h01, 8'h01, 8'hFF);
    add(1, 8'h32, 8'h00, 8'h01, 8'h01, 8'hFF);
    add(1, 8'h32, 8'h00, 8'h01, 8'h01, 8'hFF);
    add(1, 8'h32, 8'h00, 8'h01, 8'h01, 8'hFF);
    add(1, 8'h32, 8'h00, 8'h02, 8'h02, 8'hFF);
    add(1, 8'h02, 8'h00, 8'h04, 8'h04, 8'hFF);
    add(1, 8'h02, 8'h00, 8'h08, 8'h08, 8'hFF);
    add(1, 8'h02, 8'h00, 8'h11, 8'h11, 8'hFF);
    add(1, 8'h02, 8'h00, 8'h23, 8'h23, 8'hFF);
    // IDLE drives nothing.
    add(1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    #2;
    foreach (vecs[i]) begin
      rst_n     = vecs[i].rst_n;
      io1.ui_in = vecs[i].ui;
      uio_drv1  = vecs[i].uio;
      tick();
      check($sformatf("vec%0d uo_out", i),  io1.uo_out,  vecs[i].uo);
      check($sformatf("vec%0d uio_out", i), io1.uio_out, vecs[i].uio_o);
      check($sformatf("vec%0d uio_oe", i),  io1.uio_oe,  vecs[i].oe);
    end

    // LFSR period: never zero, returns to SEED after exactly 255 steps.
    io1.ui_in = 8'h02;
    tick();
    check("lfsr start", io1.uio_out, 8'h01);
    p = 8'h01;
    period = 0;
    seen_zero = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      p = lfsr_ref(p);
      check($sformatf("lfsr step%0d", i), io1.uio_out, p);
      if (io1.uio_out == 8'h00) seen_zero = 1'b1;
      if (io1.uio_out == 8'h01 && period == 0) period = i;
    end
    check("lfsr never zero", {7'd0, seen_zero}, 8'h00);
    check("lfsr period", period[7:0], 8'd255);

    // Zero-state recovery on the zero-tap instance.
    io2.ui_in = 8'h02;
    tick();
    check("lfsr0 start", io2.uio_out, 8'h01);
    exp2 = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h01, 8'h02};
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("lfsr0 step%0d", i), io2.uio_out, exp2[i]);
    end

    // Small error counter saturates at 3.
    io2.ui_in = 8'h03;
    uio_drv2 = 8'h00;
    tick();
    check("sat2 start", io2.uo_out, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("sat2 step%0d", i), io2.uo_out, (i < 3) ? 8'(i) : 8'd3);
    end

    // LOOP with loopback tied: 100 clean steps.
    io1.ui_in = 8'h00;
    tick();
    io1.ui_in = 8'h07;
    tick();
    check("loop clr uo", io1.uo_out, 8'h00);
    check("loop clr uio", io1.uio_out, 8'h01);
    io1.ui_in = 8'h03;
    tie1 = 1'b1;
    p = 8'h01;
    for (int i = 0; i < 100; i++) begin
      tick();
      p = p + 8'd1;
      check($sformatf("tie%0d uo", i), io1.uo_out, 8'h00);
      check($sformatf("tie%0d uio", i), io1.uio_out, {4'h0, p[3:0]});
    end

    // Loopback forced to 0: counts nonzero nibbles, saturating at 255.
    tie1 = 1'b0;
    uio_drv1 = 8'h00;
    e = 8'h00;
    for (int i = 0; i < 300; i++) begin
      if (p[3:0] != 4'h0 && e != 8'hFF) e = e + 8'd1;
      p = p + 8'd1;
      tick();
      check($sformatf("miss%0d uo", i), io1.uo_out, e);
    end
    io1.ui_in = 8'h07;
    tick();
    check("clear after sat", io1.uo_out, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
